// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU operation issuer: state encoding, command width
// and the ALU command codes used by the control path.
package alu_op_issuer_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;

  localparam int unsigned ALU_CMD_W = 4;
  // Wide enough for the largest legal settle time (15 cycles).
  localparam int unsigned WCNT_W    = 4;

  typedef enum logic {
    StIdle = IDLE,
    StWait = WAIT
  } state_e;

  // Command codes are opaque to the issuer; listed here for control-path users.
  localparam logic [ALU_CMD_W-1:0] CMD_ADD = 4'h0;
  localparam logic [ALU_CMD_W-1:0] CMD_SUB = 4'h1;
  localparam logic [ALU_CMD_W-1:0] CMD_AND = 4'h2;
  localparam logic [ALU_CMD_W-1:0] CMD_OR  = 4'h3;
  localparam logic [ALU_CMD_W-1:0] CMD_XOR = 4'h4;
  localparam logic [ALU_CMD_W-1:0] CMD_SHL = 4'h5;
  localparam logic [ALU_CMD_W-1:0] CMD_SHR = 4'h6;
  localparam logic [ALU_CMD_W-1:0] CMD_MUL = 4'h7;

endpackage

// File: rtl/alu_op_issuer.sv
// Sequential initiator for an external combinational ALU: drives A/B/CMD, samples Z after
// ALU_LAT cycles, optionally feeds Z back as A for repeated application of one command.
module alu_op_issuer
  import alu_op_issuer_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N-1:0]         req_a,
  input  logic [N-1:0]         req_b,
  input  logic [ALU_CMD_W-1:0] req_cmd,
  input  logic [CNT_W-1:0]     req_cnt,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  input  logic [N-1:0]         alu_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_z,
  output logic [CNT_W-1:0]     rsp_iters,
  output logic                 busy
);

  localparam logic [WCNT_W-1:0] LatInit  = WCNT_W'(ALU_LAT);
  localparam logic [WCNT_W-1:0] WcntOne  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [CNT_W-1:0]    remaining_q;
  logic [CNT_W-1:0]    iters_q;
  logic [CNT_W-1:0]    eff_cnt;

  // A zero iteration count behaves as a single application.
  assign eff_cnt = (req_cnt == '0) ? CntOne : req_cnt;

  // Accept only when the response slot is empty or draining on this same edge.
  assign req_ready = rst_n && (state_q == StIdle) && (!rsp_valid || rsp_ready);
  assign busy      = (state_q == StWait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      remaining_q <= '0;
      iters_q     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cmd     <= '0;
      rsp_valid   <= 1'b0;
      rsp_z       <= '0;
      rsp_iters   <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            alu_a       <= req_a;
            alu_b       <= req_b;
            alu_cmd     <= req_cmd;
            remaining_q <= eff_cnt;
            iters_q     <= eff_cnt;
            wcnt_q      <= LatInit;
            state_q     <= StWait;
          end
        end

        StWait: begin
          if (wcnt_q != WcntOne) begin
            wcnt_q <= wcnt_q - WcntOne;
          end else if (remaining_q != CntOne) begin
            // Feed Z back as the next A; B and CMD stay put for the whole chain.
            alu_a       <= alu_z;
            remaining_q <= remaining_q - CntOne;
            wcnt_q      <= LatInit;
          end else begin
            // rsp_valid is always clear here: entering WAIT required an empty slot.
            rsp_z     <= alu_z;
            rsp_iters <= iters_q;
            rsp_valid <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with an adder stub standing in for the ALU (ALU_LAT=1).
module tb_alu_op_issuer;

  localparam int unsigned N     = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [N-1:0]     req_a = '0;
  logic [N-1:0]     req_b = '0;
  logic [3:0]       req_cmd = '0;
  logic [CNT_W-1:0] req_cnt = '0;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [3:0]       alu_cmd;
  logic [N-1:0]     alu_z;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [N-1:0]     rsp_z;
  logic [CNT_W-1:0] rsp_iters;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_z = alu_a + alu_b;

  alu_op_issuer #(
    .N       (N),
    .CNT_W   (CNT_W),
    .ALU_LAT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cmd   (req_cmd),
    .req_cnt   (req_cnt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cmd   (alu_cmd),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_iters (rsp_iters),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, then withdraw it.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] cmd,
                      input logic [CNT_W-1:0] cnt);
    int n = 0;
    req_a     = a;
    req_b     = b;
    req_cmd   = cmd;
    req_cnt   = cnt;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Count edges until rsp_valid rises (the accept edge is already behind us).
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    step();
    while (!rsp_valid && cyc < 1000) begin
      step();
      cyc++;
    end
    check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin
    int cyc;

    // Reset state
    #2;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_rsp_z", 64'(rsp_z), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("idle_ready", {63'd0, req_ready}, 64'd1);

    // Single op: 5+7
    send(32'd5, 32'd7, 4'd0, 8'd1);
    check("single_busy", {63'd0, busy}, 64'd1);
    check("single_alu_a", 64'(alu_a), 64'd5);
    check("single_alu_b", 64'(alu_b), 64'd7);
    check("single_nv", {63'd0, rsp_valid}, 64'd0);
    step();
    check("single_valid", {63'd0, rsp_valid}, 64'd1);
    check("single_z", 64'(rsp_z), 64'd12);
    check("single_iters", 64'(rsp_iters), 64'd1);
    check("single_idle", {63'd0, busy}, 64'd0);
    step();
    check("single_drain", {63'd0, rsp_valid}, 64'd0);

    // Chained: 3 + 4*10
    send(32'd3, 32'd10, 4'd0, 8'd4);
    check("chain_a0", 64'(alu_a), 64'd3);
    step();
    check("chain_a1", 64'(alu_a), 64'd13);
    step();
    check("chain_a2", 64'(alu_a), 64'd23);
    step();
    check("chain_a3", 64'(alu_a), 64'd33);
    check("chain_nv", {63'd0, rsp_valid}, 64'd0);
    step();
    check("chain_valid", {63'd0, rsp_valid}, 64'd1);
    check("chain_z", 64'(rsp_z), 64'd43);
    check("chain_iters", 64'(rsp_iters), 64'd4);
    step();

    // Zero count acts as one
    send(32'd1, 32'd1, 4'd2, 8'd0);
    check("zero_cmd", 64'(alu_cmd), 64'd2);
    step();
    check("zero_valid", {63'd0, rsp_valid}, 64'd1);
    check("zero_z", 64'(rsp_z), 64'd2);
    check("zero_iters", 64'(rsp_iters), 64'd1);
    step();

    // Back-pressure then zero-bubble drain+accept
    rsp_ready = 1'b0;
    send(32'd20, 32'd22, 4'd0, 8'd1);
    step();
    req_a     = 32'd100;
    req_b     = 32'd200;
    req_cnt   = 8'd1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_z", 64'(rsp_z), 64'd42);
      check("bp_ready", {63'd0, req_ready}, 64'd0);
      check("bp_alu_a", 64'(alu_a), 64'd20);
      check("bp_alu_b", 64'(alu_b), 64'd22);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    check("bp_drained", {63'd0, rsp_valid}, 64'd0);
    check("bp_accepted", {63'd0, busy}, 64'd1);
    check("bp_new_a", 64'(alu_a), 64'd100);
    step();
    check("bp_new_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_new_z", 64'(rsp_z), 64'd300);
    step();

    // Reset mid-operation
    send(32'd1, 32'd1, 4'd0, 8'd8);
    step();
    step();
    step();
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_alu_a", 64'(alu_a), 64'd0);
    check("abort_alu_b", 64'(alu_b), 64'd0);
    check("abort_rsp_z", 64'(rsp_z), 64'd0);
    check("abort_iters", 64'(rsp_iters), 64'd0);
    check("abort_ready", {63'd0, req_ready}, 64'd0);
    step();
    step();
    check("abort_nv", {63'd0, rsp_valid}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    send(32'd2, 32'd2, 4'd0, 8'd1);
    step();
    check("post_rst_valid", {63'd0, rsp_valid}, 64'd1);
    check("post_rst_z", 64'(rsp_z), 64'd4);
    step();

    // Wrap-around comes from the ALU
    send(32'hFFFF_FFFF, 32'd1, 4'd0, 8'd1);
    step();
    check("wrap_valid", {63'd0, rsp_valid}, 64'd1);
    check("wrap_z", 64'(rsp_z), 64'd0);
    step();

    // Maximum count: 255 iterations of +1, latency k*ALU_LAT edges
    send(32'd0, 32'd1, 4'd0, 8'd255);
    wait_rsp(cyc);
    check("max_latency", 64'(cyc), 64'd255);
    check("max_z", 64'(rsp_z), 64'd255);
    check("max_iters", 64'(rsp_iters), 64'd255);
    step();
    check("max_drain", {63'd0, rsp_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
